// File: rtl/stx_arbiter_if.sv
// rtl/stx_arbiter_if.sv - requester/transmitter side bundle of the serial-transmit arbiter
// master: arbiter side; slave: requesters and transmitter side.
interface stx_arbiter_if;
   logic [3:0]  Req;
   logic [31:0] Din;
   logic [3:0]  Ack;
   logic [1:0]  GrantId;
   logic        Busy;
   logic        Send;
   logic [7:0]  PDout;

   modport master (
      input  Req, Din,
      output Ack, GrantId, Busy, Send, PDout
   );

   modport slave (
      output Req, Din,
      input  Ack, GrantId, Busy, Send, PDout
   );
endinterface

// File: rtl/stx_arbiter.sv
// rtl/stx_arbiter.sv - round-robin scheduler sharing one serial transmitter among four requesters
// One grant per frame; no new grant until the frame and its idle gap have elapsed.
module stx_arbiter #(
   parameter int FRAME_LEN = 9,
   parameter int GAP       = 2
) (
   input  logic          Clk,
   input  logic          Rst_n,
   stx_arbiter_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [1:0] last, last_nxt;
   logic [1:0] grant_id, grant_id_nxt;
   logic [7:0] pdout, pdout_nxt;
   logic [3:0] ack, ack_nxt;
   logic       send, send_nxt;
   logic       busy, busy_nxt;
   logic       found;
   logic [1:0] win;
   logic [1:0] idx;

   // Search starts just after the last winner, so the last winner is checked last.
   always_comb begin
      found = 1'b0;
      win   = last;
      idx   = last;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && bus.Req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      last_nxt     = last;
      grant_id_nxt = grant_id;
      pdout_nxt    = pdout;
      ack_nxt      = 4'b0000;
      send_nxt     = 1'b0;
      busy_nxt     = busy;
      case (state)
         S_IDLE: begin
            busy_nxt = 1'b0;
            if (found) begin
               state_nxt    = S_LOAD;
               pdout_nxt    = bus.Din[8*win +: 8];
               grant_id_nxt = win;
               last_nxt     = win;
               send_nxt     = 1'b1;
               ack_nxt      = 4'b0001 << win;
               busy_nxt     = 1'b1;
            end
         end
         S_LOAD: begin
            cnt_nxt   = 4'(FRAME_LEN - 1);
            state_nxt = S_SHIFT;
            busy_nxt  = 1'b1;
         end
         S_SHIFT: begin
            busy_nxt = 1'b1;
            if (cnt == 4'd0) begin
               cnt_nxt   = 4'(GAP - 1);
               state_nxt = S_GAP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_GAP: begin
            // Busy falls together with the return to IDLE so it covers LOAD..GAP exactly.
            if (cnt == 4'd0) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt  = cnt - 4'd1;
               busy_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         last     <= 2'd3;
         grant_id <= 2'd0;
         pdout    <= 8'h00;
         ack      <= 4'b0000;
         send     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         last     <= last_nxt;
         grant_id <= grant_id_nxt;
         pdout    <= pdout_nxt;
         ack      <= ack_nxt;
         send     <= send_nxt;
         busy     <= busy_nxt;
      end
   end

   assign bus.Ack     = ack;
   assign bus.GrantId = grant_id;
   assign bus.Busy    = busy;
   assign bus.Send    = send;
   assign bus.PDout   = pdout;
endmodule

// File: doc/stx_arbiter.md
# stx_arbiter

Round-robin scheduler that shares one serial transmitter among four byte requesters. It picks one pending requester and latches that requester's byte onto the transmitter's parallel input. It then issues a single-cycle `Send` pulse and holds off further requests until the 9-bit frame (8 data bits plus parity) has fully shifted out and an idle gap has elapsed. It sits directly in front of the serial transmitter; its `Send`/`PDout` drive the transmitter's `Send`/`PDin`.

## Interface
- `FRAME_LEN`, default 9: transmitter shift cycles per frame (8 data + 1 parity); legal 2..15.
- `GAP`, default 2: forced idle cycles after each frame with `Send` low; legal 1..15.
- `Clk` input, 1 bit: single clock, rising edge.
- `Rst_n` input, 1 bit: asynchronous active-low reset.
- `Req` input, 4 bits: per-requester transmit request, level. Held high until the matching `Ack`.
- `Din` input, 32 bits: requester bytes; requester i uses `Din[8*i+7:8*i]`.
- `Ack` output, 4 bits: one-hot, one-cycle pulse telling the granted requester its byte has been taken.
- `GrantId` output, 2 bits: index of the current or last granted requester.
- `Busy` output, 1 bit: high while a frame is loading, shifting or in gap.
- `Send` output, 1 bit: load strobe to the transmitter, one cycle wide.
- `PDout` output, 8 bits: byte presented to the transmitter, stable from `Send` through the end of SHIFT.

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP. All outputs are registered.
- IDLE:
  - If any `Req` is high, the round-robin winner is chosen combinationally.
  - At the clock edge: latch the winner's `Din` byte into `PDout`, set `GrantId` to the winner, update the pointer to the winner, and go to LOAD.
  - If no `Req` is high, stay in IDLE.
- Round robin:
  - `last` pointer is 2 bits, reset value 3.
  - Search order is `last+1`, `last+2`, `last+3`, `last` (modulo 4).
  - Therefore requester 0 has priority after reset, and the last winner has lowest priority.
- LOAD, exactly 1 cycle:
  - `Send=1`, `Ack[GrantId]=1`, `Busy=1`.
  - Counter loads `FRAME_LEN-1`; next state is SHIFT.
- SHIFT, `FRAME_LEN` cycles:
  - `Send=0`, `Busy=1`, counter decrements each cycle.
  - On the cycle the counter is 0, reload it to `GAP-1` and go to GAP.
- GAP, `GAP` cycles:
  - `Send=0`, `Busy=1`, counter decrements.
  - On the cycle the counter is 0, go to IDLE.
- The counter is 4 bits and uses unsigned decrement; it never wraps below 0 in normal operation.
- `Req` dropping before it is granted: the requester is simply not considered. No error is raised.
- `Req` of the granted requester still high after its `Ack`: treated as a new request and arbitrated normally at the next IDLE.
- `Din` changes after the latch edge do not affect `PDout`.
- Reset, asynchronous, including mid-frame:
  - Immediately: state IDLE, `Send=0`, `Ack=0`, `Busy=0`, `PDout=8'h00`, `GrantId=0`, `last=3`, counter 0.
  - An interrupted frame is abandoned; it is not resumed.

## Timing
- Grant latency: `Req` high and sampled in IDLE at edge k means `Send`/`Ack` are high during cycle k+1.
- Frame period, back-to-back: 1 (IDLE) + 1 (LOAD) + `FRAME_LEN` + `GAP` cycles, i.e. 13 cycles with defaults.
- `Busy` is high for `1+FRAME_LEN+GAP` consecutive cycles per frame (12 with defaults).
- `Send` is never high on two consecutive cycles. There are at least `FRAME_LEN+GAP+1` low cycles between pulses, so the transmitter always sees a clean rising edge.
- `Ack` coincides exactly with `Send`.

## Test plan
- Reset:
  - Stimulus: assert `Rst_n=0` asynchronously between edges.
  - Required: all outputs go to 0 without waiting for a clock edge; after release, `Busy=0` with `Req=0`.
- Single request:
  - Stimulus: `Req=4'b0100`, byte 2 = `8'hA5`, sampled at edge 0.
  - Required in cycle 1: `Send=1`, `Ack=4'b0100`, `GrantId=2`, `PDout=8'hA5`.
  - Required after: `Busy` high cycles 1–12, IDLE at cycle 13. Bench transmitter serial output shows 1,0,1,0,0,1,0,1 followed by parity 0.
- Full contention:
  - Stimulus: `Req=4'b1111` held continuously after reset.
  - Required: grants in order 0,1,2,3,0; `Send` pulses exactly 13 cycles apart.
- Fairness:
  - Stimulus: after a grant to requester 1, hold `Req=4'b1010`.
  - Required: next grant is 3, then 1; requester 3 is never starved.
- Mid-frame reset:
  - Stimulus: pulse `Rst_n` low in the 4th SHIFT cycle of a frame for requester 2, with `Req=4'b0101` held.
  - Required: `Send`/`Busy` drop immediately; the first grant after release is to requester 0.
- Data stability:
  - Stimulus: change `Din` of the granted requester every cycle during SHIFT.
  - Required: `PDout` stays constant until the next LOAD.
